// File: rtl/shift_word_serializer.sv
// Serializes one parallel word per handshake, MSB-first, framed by start/stop bits.
// Optional even-parity bit before STOP when SHIFT_WORD_SERIALIZER_PARITY_EN is defined.
module shift_word_serializer #(
   parameter int DATA_W   = 8,
   parameter int BAUD_DIV = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              ser_out,
   output logic              busy,
   output logic              done
);

   localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int CW = $clog2(DATA_W);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_W - 1);

`ifdef SHIFT_WORD_SERIALIZER_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t            state, state_n;
   logic [BW-1:0]     baud_cnt, baud_n;
   logic [CW-1:0]     bit_cnt, bit_n;
   logic [DATA_W-1:0] shreg, shreg_n;
   logic              ser_n;
   logic              tick;
`ifdef SHIFT_WORD_SERIALIZER_PARITY_EN
   logic              par_q, par_n;
`endif

   assign tick     = (baud_cnt == BAUD_LAST);
   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   always_comb begin
      state_n = state;
      baud_n  = (state == IDLE || tick) ? '0 : baud_cnt + 1'b1;
      bit_n   = bit_cnt;
      shreg_n = shreg;
      done    = 1'b0;
`ifdef SHIFT_WORD_SERIALIZER_PARITY_EN
      par_n   = par_q;
`endif
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               state_n = START;
               shreg_n = in_data;
`ifdef SHIFT_WORD_SERIALIZER_PARITY_EN
               par_n   = ^in_data;
`endif
            end
         end
         START: begin
            if (tick) state_n = DATA;
         end
         DATA: begin
            if (tick) begin
               shreg_n = {shreg[DATA_W-2:0], 1'b0};
               if (bit_cnt == BIT_LAST) begin
                  bit_n = '0;
`ifdef SHIFT_WORD_SERIALIZER_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end else begin
                  bit_n = bit_cnt + 1'b1;
               end
            end
         end
`ifdef SHIFT_WORD_SERIALIZER_PARITY_EN
         PARITY: begin
            if (tick) state_n = STOP;
         end
`endif
         STOP: begin
            if (tick) begin
               done    = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Line level is decoded from the next state so ser_out stays a pure flop.
   always_comb begin
      ser_n = 1'b1;
      unique case (state_n)
         START:   ser_n = 1'b0;
         DATA:    ser_n = shreg_n[DATA_W-1];
`ifdef SHIFT_WORD_SERIALIZER_PARITY_EN
         PARITY:  ser_n = par_n;
`endif
         default: ser_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         ser_out  <= 1'b1;
`ifdef SHIFT_WORD_SERIALIZER_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         baud_cnt <= baud_n;
         bit_cnt  <= bit_n;
         shreg    <= shreg_n;
         ser_out  <= ser_n;
`ifdef SHIFT_WORD_SERIALIZER_PARITY_EN
         par_q    <= par_n;
`endif
      end
   end

endmodule

// File: tb/tb_shift_word_serializer.sv
// Directed bench for shift_word_serializer: BAUD_DIV=4 and BAUD_DIV=1 instances.
// Honours SHIFT_WORD_SERIALIZER_PARITY_EN for frame length and parity bit.
module tb_shift_word_serializer;

`ifdef SHIFT_WORD_SERIALIZER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int BD = 4;
   localparam int NB = 10 + PAR;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       in_ready, ser_out, busy, done;
   logic [7:0] d1 = '0;
   logic       v1 = 1'b0;
   logic       r1, s1, b1, dn1;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   shift_word_serializer #(.DATA_W(8), .BAUD_DIV(BD)) dut (
      .clk(clk), .reset_n(reset_n), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .ser_out(ser_out),
      .busy(busy), .done(done)
   );

   shift_word_serializer #(.DATA_W(8), .BAUD_DIV(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .in_data(d1),
      .in_valid(v1), .in_ready(r1), .ser_out(s1),
      .busy(b1), .done(dn1)
   );

   typedef struct {
      logic [7:0] word;
      logic [9:0] line;
      logic       par;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic exp_bit(vec_t v, int c, int bd);
      int idx;
      idx = (c - 1) / bd;
      if (idx < 9) return v.line[9-idx];
      if (PAR == 1 && idx == 9) return v.par;
      return 1'b1;
   endfunction

   // Entered in cycle 1 after the accepting edge; leaves in the idle cycle.
   task automatic check_frame(input vec_t v, input bit sel, input int bd);
      int fl;
      fl = NB * bd;
      for (int c = 1; c <= fl; c++) begin
         chk($sformatf("ser w%h c%0d", v.word, c),
             sel ? s1 : ser_out, exp_bit(v, c, bd));
         chk($sformatf("in_ready w%h c%0d", v.word, c),
             sel ? r1 : in_ready, 0);
         chk($sformatf("busy w%h c%0d", v.word, c),
             sel ? b1 : busy, 1);
         chk($sformatf("done w%h c%0d", v.word, c),
             sel ? dn1 : done, (c == fl));
         step();
      end
      chk($sformatf("idle ser w%h", v.word), sel ? s1 : ser_out, 1);
      chk($sformatf("idle ready w%h", v.word), sel ? r1 : in_ready, 1);
      chk($sformatf("idle busy w%h", v.word), sel ? b1 : busy, 0);
      chk($sformatf("idle done w%h", v.word), sel ? dn1 : done, 0);
   endtask

   task automatic send(input vec_t v);
      chk("ready before send", in_ready, 1);
      in_valid = 1'b1;
      in_data  = v.word;
      step();
      in_valid = 1'b0;
      check_frame(v, 1'b0, BD);
   endtask

   initial begin
      vecs[0] = '{8'hA5, 10'b0_1010_0101_1, 1'b0};
      vecs[1] = '{8'h3C, 10'b0_0011_1100_1, 1'b0};
      vecs[2] = '{8'hF0, 10'b0_1111_0000_1, 1'b0};
      vecs[3] = '{8'h00, 10'b0_0000_0000_1, 1'b0};
      vecs[4] = '{8'hFF, 10'b0_1111_1111_1, 1'b0};
      vecs[5] = '{8'h07, 10'b0_0000_0111_1, 1'b1};
      vecs[6] = '{8'h03, 10'b0_0000_0011_1, 1'b0};
      vecs[7] = '{8'h80, 10'b0_1000_0000_1, 1'b1};

      // Reset held with in_valid high: nothing may be captured.
      in_valid = 1'b1;
      in_data  = 8'hA5;
      v1 = 1'b1;
      d1 = 8'hFF;
      #1 reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst ser", ser_out, 1);
         chk("rst ready", in_ready, 1);
         chk("rst busy", busy, 0);
         chk("rst done", done, 0);
         chk("rst ser1", s1, 1);
      end
      in_valid = 1'b0;
      v1 = 1'b0;
      reset_n = 1'b1;
      step();
      chk("post rst busy", busy, 0);
      chk("post rst ser", ser_out, 1);
      chk("post rst busy1", b1, 0);

      for (int i = 0; i < 8; i++) send(vecs[i]);

      // in_valid held across a frame: next word taken on the single idle cycle.
      in_valid = 1'b1;
      in_data  = 8'hA5;
      step();
      in_data = 8'h3C;
      check_frame(vecs[0], 1'b0, BD);
      step();
      in_valid = 1'b0;
      check_frame(vecs[1], 1'b0, BD);

      // Abort mid-DATA at data bit 3 (line 1) and bit 4 (line 0).
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1;
         in_data  = 8'hF0;
         step();
         in_valid = 1'b0;
         repeat (17 + 4 * k) step();
         chk($sformatf("pre abort ser k%0d", k), ser_out,
             exp_bit(vecs[2], 18 + 4 * k, BD));
         chk($sformatf("pre abort busy k%0d", k), busy, 1);
         #1 reset_n = 1'b0;
         #1;
         chk($sformatf("abort ser k%0d", k), ser_out, 1);
         chk($sformatf("abort busy k%0d", k), busy, 0);
         chk($sformatf("abort ready k%0d", k), in_ready, 1);
         chk($sformatf("abort done k%0d", k), done, 0);
         repeat (2) begin
            step();
            chk($sformatf("abort hold done k%0d", k), done, 0);
            chk($sformatf("abort hold ser k%0d", k), ser_out, 1);
         end
         reset_n = 1'b1;
         step();
         chk($sformatf("after abort ready k%0d", k), in_ready, 1);
         chk($sformatf("after abort done k%0d", k), done, 0);
      end
      send(vecs[1]);

      // BAUD_DIV=1, back-to-back FF then 00.
      v1 = 1'b1;
      d1 = 8'hFF;
      step();
      d1 = 8'h00;
      check_frame(vecs[4], 1'b1, 1);
      step();
      v1 = 1'b0;
      check_frame(vecs[3], 1'b1, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_word_serializer.md
Name: shift_word_serializer

Overview:
- Downstream consumer of the 8-bit left-shift stage.
- Accepts one parallel word per valid/ready handshake and transmits it MSB-first on a single serial line.
- Frame format: start bit, data bits, stop bit; each bit is held for a programmable number of clock cycles.
- The serial line feeds the board-level link or a loopback deserializer in the bench.

Parameters:
- DATA_W, 8, width of the parallel word; must be >= 2.
- BAUD_DIV, 4, clock cycles per serial bit; must be >= 1.

Ports:
- clk  input  1  single system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  DATA_W  word to transmit; sampled only on handshake.
- in_valid  input  1  upstream has a word on in_data.
- in_ready  output  1  block can accept a word; equals (state==IDLE).
- ser_out  output  1  registered serial line; idle level is 1.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on the last cycle of STOP.

Behaviour:
- Interface: one clock (clk); reset is asynchronous, active-low (reset_n). Every flop clears immediately when reset_n=0, independent of clk.
- Reset values:
  - state=IDLE, ser_out=1, in_ready=1, busy=0, done=0.
  - Shift register, bit counter and baud counter = 0.
- Handshake: a transfer occurs on a rising edge with in_valid=1 and in_ready=1.
  - in_data is captured into the shift register and state goes to START.
  - in_valid while in_ready=0 is ignored. No buffering; upstream must hold the word.
- Latency: ser_out drops to 0 in the first cycle after the accepting edge.
- Bit timing: a baud counter counts 0..BAUD_DIV-1 in each state. The state advances when the counter reaches BAUD_DIV-1, then the counter wraps to 0.
- States:
  - IDLE: ser_out=1. Go to START on handshake.
  - START: ser_out=0 for BAUD_DIV cycles, then DATA.
  - DATA: ser_out = shreg[DATA_W-1]. At each bit-period end, shreg shifts left with 0 fill and bit_cnt increments. Leave when bit_cnt==DATA_W-1 at period end, with bit_cnt cleared.
  - STOP: ser_out=1 for BAUD_DIV cycles. done=1 in its final cycle, then IDLE.
- Frame length is (DATA_W+2)*BAUD_DIV cycles.
- IDLE lasts at least one cycle between frames, so max throughput is one word per (DATA_W+2)*BAUD_DIV+1 cycles.
- Reset mid-frame: the frame is aborted and the word discarded. ser_out returns to 1 asynchronously. No done pulse.
- ser_out is driven directly from a flop: no glitches, no combinational path from in_data.

Optional Feature:
- Macro: SHIFT_WORD_SERIALIZER_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - ser_out = even parity (XOR of all captured data bits) for BAUD_DIV cycles.
  - Parity is computed at capture and held in a flop.
  - Frame = (DATA_W+3)*BAUD_DIV cycles.
- Undefined: no PARITY state, no parity flop, frame = (DATA_W+2)*BAUD_DIV cycles.

Test Plan:
1. reset_n=0 for 3 cycles, in_valid=1 -> ser_out=1, in_ready=1, busy=0, done=0 throughout; no capture.
2. DATA_W=8, BAUD_DIV=4, send 8'hA5 -> line shows 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. in_ready=0 for cycles 1..40 after accept; done pulses in cycle 40.
3. Hold in_valid=1 with 8'h3C during the 8'hA5 frame -> 8'h3C is accepted on the single IDLE cycle after done. The two frames are separated by exactly one idle-high cycle, and 8'h3C serializes as 0,0,0,1,1,1,1,0,0,1.
4. Assert reset_n=0 mid-DATA at bit 3 of 8'hF0 -> ser_out=1 in the same cycle, busy=0, no done pulse. After release, in_ready=1 and the next word transmits from its start bit.
5. With SHIFT_WORD_SERIALIZER_PARITY_EN, send 8'h07 -> parity bit 1; send 8'h03 -> parity bit 0. Each frame is 44 cycles and done is delayed accordingly.
6. BAUD_DIV=1, back-to-back 8'hFF then 8'h00 with in_valid held high -> each bit lasts 1 cycle, 10-cycle frames separated by 1 idle cycle. Line shows 0,1×8,1,1,0,0×8,1.
